// File: rtl/sort_job_arbiter.sv
// Shares one sorter between NREQ requesters: round-robin grant, start pulse, guarded wait, result return.
// Latency: accept -> srt_start next cycle; done accepted in cycle d -> rsp_valid from d+1; timeout after TIMEOUT WAIT cycles.
// Backpressure: req_ready only in IDLE; result held in RESP until the owner's rsp_ready, new requests stall meanwhile.
module sort_job_arbiter #(
    parameter int N       = 6,
    parameter int WIDTH   = 8,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64,
    localparam int OW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [WIDTH-1:0]     req_data [NREQ][N],
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [WIDTH-1:0]     rsp_data [N],
    output logic                 rsp_timeout,
    output logic                 srt_start,
    output logic [WIDTH-1:0]     srt_data [N],
    input  logic                 srt_done,
    input  logic [WIDTH-1:0]     srt_data_sorted [N],
    output logic                 busy,
    output logic [OW-1:0]        owner
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    logic [OW-1:0]   ptr;
    logic [TW-1:0]   timer;
    logic            found;
    logic [OW-1:0]   win;
    int              idx;
    logic            accept;
    logic            rsp_hs;
    logic            done_ok;
    logic            last_wait;
    logic [OW-1:0]   next_ptr;

    // Winner is the first valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = OW'(idx);
            end
        end
    end

    assign accept = (state == S_IDLE) && found;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win] = 1'b1;
    end

    assign rsp_hs    = (state == S_RESP) && rsp_ready[owner];
    // timer == 0 is the first WAIT cycle, where a done level left over from the previous job may linger.
    assign done_ok   = srt_done && (timer != '0);
    assign last_wait = (timer == TW'(TIMEOUT - 1));
    assign next_ptr  = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;

    // srt_data doubles as the job register and rsp_data as the result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            timer       <= '0;
            owner       <= '0;
            busy        <= 1'b0;
            srt_start   <= 1'b0;
            rsp_valid   <= '0;
            rsp_timeout <= 1'b0;
            for (int i = 0; i < N; i++) begin
                srt_data[i] <= '0;
                rsp_data[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < N; i++) srt_data[i] <= req_data[win][i];
                        owner     <= win;
                        busy      <= 1'b1;
                        srt_start <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    srt_start <= 1'b0;
                    timer     <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    if (done_ok) begin
                        for (int i = 0; i < N; i++) rsp_data[i] <= srt_data_sorted[i];
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= NREQ'(1) << owner;
                        state       <= S_RESP;
                    end else if (last_wait) begin
                        for (int i = 0; i < N; i++) rsp_data[i] <= srt_data[i];
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= NREQ'(1) << owner;
                        state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_hs) begin
                        rsp_valid <= '0;
                        ptr       <= next_ptr;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sort_job_arbiter.md
# sort_job_arbiter

Controller that shares one `fsm_sort` instance (N-element, WIDTH-bit sorter with `start`/`done` level handshake) between NREQ requesters. It arbitrates round-robin, captures the winner's vector, pulses the sorter's `start`, and waits for `done` under a timeout guard. It then returns the sorted vector to the owning requester over a valid/ready response channel. It sits between the client blocks and the single sorter datapath.

## Interface
- `N`, 6, elements per vector (matches sorter)
- `WIDTH`, 8, bits per element
- `NREQ`, 2, number of requesters (≥1)
- `TIMEOUT`, 64, max WAIT cycles before job is abandoned (≥2)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  NREQ  requester i has a job
- `req_data`  in  [NREQ][N] x WIDTH  job vectors, unpacked array
- `req_ready`  out  NREQ  one-hot accept; transfer when `req_valid[i] & req_ready[i]`
- `rsp_valid`  out  NREQ  one-hot result valid for owner
- `rsp_ready`  in  NREQ  requester accepts result
- `rsp_data`  out  [N] x WIDTH  result vector
- `rsp_timeout`  out  1  result is a timeout (`rsp_data` = unsorted input)
- `srt_start`  out  1  to sorter `start`
- `srt_data`  out  [N] x WIDTH  to sorter `data_in`
- `srt_done`  in  1  from sorter `done` (level)
- `srt_data_sorted`  in  [N] x WIDTH  from sorter `data_sorted`
- `busy`  out  1  state ≠ IDLE
- `owner`  out  max(1,$clog2(NREQ))  index of current job's requester

## Operation
- States: IDLE → START → WAIT → RESP → IDLE.
- Round-robin pointer `ptr`. Winner = first i with `req_valid[i]`, searching `ptr, ptr+1, …` mod NREQ.
- IDLE: `req_ready[winner]`=1, combinational from `req_valid`/`ptr`; all others 0. On transfer: `job_reg`←`req_data[winner]`, `owner`←winner, go START. No valid request: stay.
- START (1 cycle): `srt_start`=1, timer←0, go WAIT. `srt_start` is 0 in every other state.
- `srt_data` = `job_reg` from START until the job leaves WAIT; constant between jobs.
- WAIT: timer increments each cycle.
  - `srt_done` is ignored during START and the first WAIT cycle, so a level held from the prior job cannot complete the new one.
  - Done accepted (WAIT cycle ≥2): `res_reg`←`srt_data_sorted`, `rsp_timeout`←0, go RESP.
  - TIMEOUT WAIT cycles elapse with no accepted done: `res_reg`←`job_reg`, `rsp_timeout`←1, go RESP. On the TIMEOUT-th cycle, done has priority over timeout.
- RESP: `rsp_valid[owner]`=1. `rsp_data`/`rsp_timeout` are held stable until `rsp_ready[owner]`=1. Then `ptr`←(owner+1) mod NREQ and go IDLE. `rsp_ready` of non-owners is ignored.
- `req_ready` is all-0 outside IDLE. Requests are never dropped, only stalled.
- Reset (any state, including mid-job): immediately state=IDLE, `ptr`=0, timer=0, `job_reg`/`res_reg`=0. The in-flight job is discarded with no response.

## Timing
- Reset values: `req_ready` is combinational, so it may be high during IDLE when `req_valid` is high. All registered outputs are 0: `rsp_valid`, `rsp_data`, `rsp_timeout`, `srt_start`, `srt_data`, `busy`, `owner`.
- Accept at edge k → `srt_start` high in cycle k+1 (exactly 1 cycle).
- Done accepted in cycle d → `rsp_valid` high from cycle d+1.
- Timeout: `rsp_valid` rises the cycle after the TIMEOUT-th WAIT cycle, TIMEOUT+1 cycles after START.
- Minimum job turnaround, accept to next possible accept: 5 cycles (START, WAIT, WAIT+done, RESP with ready, IDLE).
- A request valid in the cycle of the RESP handshake is accepted no earlier than the following IDLE cycle.

## Test plan
- Single job: req 0 = {5,0,2,1,1,3}, sorter model raises done 8 cycles after start → one-cycle `srt_start` the cycle after accept, `srt_data`={5,0,2,1,1,3}; `rsp_valid[0]` with {0,1,1,2,3,5}, `rsp_timeout`=0.
- Fairness: `req_valid`=2'b11 held for 4 jobs, distinct vectors → grant order 0,1,0,1; each `rsp_valid` one-hot to the correct owner with that owner's data sorted.
- Backpressure: hold `rsp_ready[0]`=0 for 5 cycles with `req_valid[1]`=1 → `rsp_data` stable, `req_ready`=0, `srt_start` stays 0; job 1 accepted only after handshake.
- Stale done: `srt_done` held 1 from the prior job, dropping after start, re-rising later with {0,1,2,3,4,5} → the early level is ignored; result is {0,1,2,3,4,5}.
- Timeout: sorter never asserts done, input {3,2,4,0,1,5} → `rsp_valid` rises 65 cycles after START with `rsp_timeout`=1 and `rsp_data`={3,2,4,0,1,5}.
- Reset mid-WAIT → all registered outputs 0 asynchronously, no `rsp_valid`; the next request after deassertion is served normally with `ptr`=0 priority.
